stream_sum: RTL and testbench
=============================

# stream_sum

- Downstream consumer stage for per-element stream mappers such as the add-one map.
- Accepts a start request carrying an element count `len`, then consumes exactly `len` elements from an input stream.
- Accumulates their unsigned sum and presents the result on a single-value output handshake.
- Closes a map/fold pipeline: stream producer → mapper → `stream_sum` → scalar consumer.

## Interface
Parameters:
- `N`, default `` `intN ``: width of stream elements, `len` and `sum`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  start request; `len` is sampled when `in_valid && in_ready`.
- `in_ready`  out  1  start accept; high only in IDLE.
- `len`  in  N  number of elements to consume, unsigned; 0 is legal.
- `sIn`  in  N  input stream data, unsigned.
- `sIn_valid`  in  1  input stream valid.
- `sIn_ready`  out  1  input stream ready; high only in ACC.
- `sum`  out  N  result; registered; holds its value outside DONE.
- `out_valid`  out  1  result valid; high only in DONE.
- `out_ready`  in  1  result accept.

## Operation
States and transitions:
- IDLE, on start accept:
  - `len == 0`: go to DONE with `acc = 0`.
  - Otherwise: go to ACC with `acc = 0` and `remaining = len`.
- ACC, on element accept (`sIn_valid && sIn_ready`):
  - `acc <= acc + sIn`, truncated to N bits (wrap modulo 2^N).
  - `remaining <= remaining - 1`.
  - If `remaining == 1` at the accept, go to DONE.
  - No accept leaves the state unchanged. Gaps in `sIn_valid` are tolerated indefinitely.
- DONE: `out_valid = 1` and `sum = acc`. On `out_ready`, go to IDLE.

General rules:
- `in_ready`, `sIn_ready` and `out_valid` are decoded from the state register only. No combinational path exists from any input to any output.
- Elements presented while not in ACC are not consumed (`sIn_ready = 0`).
- `len` is latched at start; later changes on `len` are ignored.
- Maximum count is 2^N − 1. `remaining` is N bits wide.

Reset:
- Asserting `nrst` low forces IDLE immediately, at any time and independent of `clk`.
- Reset mid-operation discards the partial sum and `remaining`. Unconsumed elements stay in the upstream stage.

Reset values:
- State IDLE.
- `in_ready = 1`, `sIn_ready = 0`, `out_valid = 0`.
- `sum = 0`, `acc = 0`, `remaining = 0`.

## Timing
- Start accept → `sIn_ready` high on the next cycle.
- Throughput: one element per cycle while `sIn_valid` is held high.
- Last element accepted at edge k → `out_valid` high and `sum` final from edge k onward (visible in cycle k+1).
- `len == 0`: start at edge k → `out_valid` from edge k, with `sum = 0`.
- Result accept at edge m → IDLE from edge m.
  - `in_ready` is high in cycle m+1, so there is one bubble between back-to-back jobs.
  - A new start in the same cycle as the result accept is not taken.
- While `out_valid && !out_ready`: `sum` and `out_valid` are held stable.
- Minimum job length for `len = L > 0`: L + 2 cycles, start to result accept.

## Configuration
- `STREAM_SUM_SAT_EN` defined:
  - The accumulator saturates at 2^N − 1.
  - Once it saturates, it stays at 2^N − 1 for the rest of the job.
  - `remaining` still counts normally, so all `len` elements are consumed.
- `STREAM_SUM_SAT_EN` undefined: the accumulator wraps modulo 2^N.
- Timing is identical in both builds.

## Test plan
- N = 8, `len = 3`, `sIn` = 1, 2, 3 back-to-back, `out_ready = 1` → `out_valid` for 1 cycle with `sum = 6`, then `in_ready = 1` the following cycle.
- `len = 0` → `sIn_ready` never rises; `out_valid` on the next cycle with `sum = 0`.
- `len = 2`, `sIn` = 200, 100 → `sum = 44` without the macro; `sum = 255` with `STREAM_SUM_SAT_EN`.
- `len = 4`, `sIn_valid` toggling 1/0 each cycle with values 5, 6, 7, 8; `out_ready = 0` for 5 cycles after the result → `sum = 26` held stable for those 5 cycles and the extra `sIn` beats are not consumed.
- Data sequence 0, 1, 2, … driven into a mapper that adds 1, with its output feeding this block, `len = 4` → `sum = 10`.
- `len = 5` with `nrst` pulsed low between clock edges after 2 elements → outputs take reset values immediately; a new `len = 1` job with `sIn = 9` → `sum = 9`.

Source files
------------

// File: rtl/stream_sum.sv
// Fold stage: takes a start request with element count len, sums len stream elements, returns the sum.
// Build option STREAM_SUM_SAT_EN: accumulator saturates at all-ones instead of wrapping.
`ifndef intN
`define intN 8
`endif

module stream_sum #(
  parameter int N = `intN
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] len,
  input  logic [N-1:0] sIn,
  input  logic         sIn_valid,
  output logic         sIn_ready,
  output logic [N-1:0] sum,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] acc, acc_nxt;
  logic [N-1:0] rem, rem_nxt;
  logic [N-1:0] sum_nxt;
  logic [N-1:0] acc_add;

`ifdef STREAM_SUM_SAT_EN
  logic [N:0] add_w;
  // A carry out means the true sum exceeds all-ones; clamp there for the rest of the job.
  always_comb begin
    add_w   = {1'b0, acc} + {1'b0, sIn};
    acc_add = add_w[N] ? '1 : add_w[N-1:0];
  end
`else
  always_comb acc_add = acc + sIn;
`endif

  // Handshake outputs decode the state register only.
  assign in_ready  = (state == IDLE);
  assign sIn_ready = (state == ACC);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    sum_nxt   = sum;
    case (state)
      IDLE: if (in_valid) begin
        acc_nxt = '0;
        rem_nxt = len;
        if (len == '0) begin
          state_nxt = DONE;
          sum_nxt   = '0;
        end else begin
          state_nxt = ACC;
        end
      end
      ACC: if (sIn_valid) begin
        acc_nxt = acc_add;
        rem_nxt = rem - N'(1);
        if (rem == N'(1)) begin
          state_nxt = DONE;
          sum_nxt   = acc_add;
        end
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      sum   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      sum   <= sum_nxt;
    end
  end

endmodule

// File: tb/tb_stream_sum.sv
// Directed bench for stream_sum: stimulus pushes expected sums, a monitor pops them on each result handshake.
module tb_stream_sum;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] len = '0;
  logic [7:0] sIn = '0;
  logic       sIn_valid = 1'b0;
  logic       sIn_ready;
  logic [7:0] sum;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  stream_sum #(.N(8)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .len(len),
    .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready), .sum(sum),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got sum %0d with no expectation queued", sum);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (sum !== e) begin
          errors++;
          $display("FAIL result_sum: got %0d expected %0d at %0t", sum, e, $time);
        end
      end
      done_cnt++;
    end
  end

  task automatic do_start(input logic [7:0] l);
    int t = 0;
    in_valid = 1'b1;
    len = l;
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t == 50) chk("start_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    len = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] v);
    int t = 0;
    sIn = v;
    sIn_valid = 1'b1;
    while (!sIn_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t == 50) chk("elem_timeout", 0, 1);
    @(posedge clk); #1;
    sIn_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 100) begin @(posedge clk); t++; end
    if (t == 100) chk("done_timeout", done_cnt, target);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sIn_ready", sIn_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1;

    // back-to-back 1,2,3
    exp_q.push_back(8'd6);
    do_start(8'd3);
    chk("start_sIn_ready", sIn_ready, 1);
    send(8'd1); send(8'd2); send(8'd3);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_sum", sum, 6);
    chk("t1_in_ready_busy", in_ready, 0);
    in_valid = 1'b1; len = 8'd7;       // start offered during result accept must not be taken
    @(posedge clk); #1;
    chk("t1_out_valid_one_cycle", out_valid, 0);
    chk("t1_in_ready_after", in_ready, 1);
    in_valid = 1'b0;
    wait_done(1);

    // len == 0
    exp_q.push_back(8'd0);
    do_start(8'd0);
    chk("len0_out_valid", out_valid, 1);
    chk("len0_sIn_ready", sIn_ready, 0);
    chk("len0_sum", sum, 0);
    wait_done(2);
    chk("len0_idle", in_ready, 1);

    // overflow
`ifdef STREAM_SUM_SAT_EN
    exp_q.push_back(8'd255);
`else
    exp_q.push_back(8'd44);
`endif
    do_start(8'd2);
    send(8'd200); send(8'd100);
    wait_done(3);

    // gaps in sIn_valid and result backpressure
    out_ready = 1'b0;
    exp_q.push_back(8'd26);
    do_start(8'd4);
    send(8'd5); @(posedge clk); #1;
    send(8'd6); @(posedge clk); #1;
    send(8'd7); @(posedge clk); #1;
    send(8'd8);
    sIn = 8'd99; sIn_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_sum", sum, 26);
      chk("hold_sIn_ready", sIn_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(4);
    sIn_valid = 1'b0;

    // mapper (add one) over 0,1,2,3
    exp_q.push_back(8'd10);
    do_start(8'd4);
    for (int i = 0; i < 4; i++) send(8'(i + 1));
    wait_done(5);

    // asynchronous reset mid-job
    do_start(8'd5);
    send(8'd3); send(8'd4);
    #2 nrst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_sIn_ready", sIn_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    @(posedge clk); #1 nrst = 1'b1;
    exp_q.push_back(8'd9);
    do_start(8'd1);
    send(8'd9);
    wait_done(6);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
